fpu_share_arbiter: RTL and testbench
====================================

Name: fpu_share_arbiter

Overview:
- Shares one s2 floating-point custom-instruction unit among NUM_REQ independent requesters, such as the per-channel mic gain sequencers.
- The s2 unit uses dataa/datab/n/start in and result/done out. n codes: 3'b010 int→float, 3'b100 fmul, 3'b001 float→int.
- Each requester issues a one-cycle start pulse with its operands. The block latches the request, grants the unit round-robin, issues the op, and routes the result back with a one-cycle done pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT without s2_done before the op is aborted.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- req_start  in  NUM_REQ  per-requester start pulse
- req_n  in  3*NUM_REQ  per-requester op code; slot i at bits [3i+2:3i]
- req_dataa  in  32*NUM_REQ  per-requester operand A; slot i at bits [32i+31:32i]
- req_datab  in  32*NUM_REQ  per-requester operand B, same slicing
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- req_result  out  32  shared result bus; valid while req_done is high, then held
- req_timeout  out  1  high with req_done when the op was aborted
- req_pending  out  NUM_REQ  request latched and not yet answered
- drop_err  out  NUM_REQ  sticky; a start arrived while that slot was already pending
- s2_dataa  out  32  operand A to the FPU
- s2_datab  out  32  operand B to the FPU
- s2_n  out  3  op code to the FPU
- s2_start  out  1  FPU start pulse
- s2_result  in  32  FPU result
- s2_done  in  1  FPU completion

Behaviour:
- Reset (async): state IDLE; rr_ptr=0; all slot registers and outputs 0. This covers s2_start, s2_dataa, s2_datab, s2_n, req_done, req_result, req_timeout, req_pending, drop_err and the timeout counter.
- Capture, per slot i, every cycle independently of the FSM:
  - If req_start[i] and pending[i]==0: latch n/dataa/datab and set pending[i].
  - If req_start[i] and pending[i]==1 and slot i is not being answered this cycle: ignore the new operands and set drop_err[i].
  - If req_start[i] arrives in the RESP cycle of slot i: the new request is latched and pending[i] stays 1. Capture wins over clear.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any pending, grant the first pending index searching upward from rr_ptr with wrap, register it as gnt, then go to ISSUE. Otherwise stay in IDLE. s2_done is ignored here.
  - ISSUE (exactly 1 cycle): s2_start=1; s2_n/dataa/datab come from slot gnt.
    - If s2_done is already high this cycle (zero-latency op), capture s2_result and go to RESP.
    - Otherwise clear the counter and go to WAIT.
  - WAIT: s2_start=0; s2 operands and n are held stable; the counter increments each cycle.
    - On s2_done: capture s2_result and go to RESP.
    - If counter==TIMEOUT_CYCLES-1 without done: result=0, set timeout flag, go to RESP. s2_done on that same cycle wins.
  - RESP (1 cycle): req_done[gnt]=1; req_result=captured value; req_timeout=flag.
    - Clear pending[gnt] (subject to the capture rule); rr_ptr=(gnt+1) mod NUM_REQ; go to IDLE.
- Outside ISSUE/WAIT, s2_dataa/datab hold their last value and s2_n holds its last value. req_result holds between RESP cycles.
- Latency with the bus idle: req_start at edge E0 → ISSUE in cycle E1–E2 → req_done in the cycle after the edge where s2_done is sampled. Minimum start-to-done is 3 cycles. Throughput is one op per (FPU latency + 3) cycles.
- The round-robin pointer advances only on a grant. No requester can wait more than NUM_REQ-1 grants.
- Reset mid-operation: everything returns to reset values. A late s2_done after reset arrives in IDLE and is ignored. No req_done is produced for ops flushed by reset.

Test Plan:
- Single int→float: slot 0 start, n=3'b010, dataa=5; FPU model done after 4 cycles, result 0x40A00000 → exactly one s2_start pulse carrying dataa=5, n=010; req_done[0] pulse with req_result=0x40A00000; pending[0] clears.
- Simultaneous starts on slots 0, 2, 3 with rr_ptr=0 → s2 ops issued in order 0,2,3; each req_done carries its own operand-derived result; rr_ptr ends at 0.
- Fairness: slots 0 and 1 each re-request in their own RESP cycle, repeated 6 times → grants alternate 0,1,0,1,0,1; no drop_err.
- Timeout: FPU never asserts done → 64 WAIT cycles, then req_done with req_timeout=1 and result 0; the next pending slot is issued normally afterwards.
- Drop: second req_start[2] with different dataa while pending[2] → drop_err[2]=1 (sticky); the s2 op uses the first operands.
- Reset asserted mid-WAIT, and a zero-latency op (s2_done high during ISSUE) → reset: all outputs 0 and no req_done; zero-latency op: req_done on the next cycle.

Source files
------------

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter
//
// Shares one s2 floating-point custom-instruction unit among NUM_REQ
// independent requesters. Each requester fires a one-cycle start pulse
// with its op code and operands. The request is latched into that
// requester's slot, slots are granted round-robin, and the op is issued
// to the FPU. The result comes back on a shared bus together with a
// one-cycle done pulse to the granted requester. An op that never
// completes is aborted after TIMEOUT_CYCLES wait cycles.
//
// Ports
//   CLK, RESET            clock, asynchronous active-high reset
//   req_start[NUM_REQ]    per-slot start pulse
//   req_n                 per-slot op code, slot i at [3i+2:3i]
//   req_dataa/req_datab   per-slot operands, slot i at [32i+31:32i]
//   req_done[NUM_REQ]     one-cycle completion pulse to the granted slot
//   req_result            shared result, valid with req_done, then held
//   req_timeout           high with req_done when the op was aborted
//   req_pending           slot holds a request not yet answered
//   drop_err              sticky: a start arrived while the slot was pending
//   s2_dataa/datab/n      operands and op code to the FPU (held after issue)
//   s2_start              one-cycle FPU start pulse
//   s2_result/s2_done     FPU result and completion

module fpu_share_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NUM_REQ-1:0]      req_start,
    input  logic [3*NUM_REQ-1:0]    req_n,
    input  logic [32*NUM_REQ-1:0]   req_dataa,
    input  logic [32*NUM_REQ-1:0]   req_datab,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [31:0]             req_result,
    output logic                    req_timeout,
    output logic [NUM_REQ-1:0]      req_pending,
    output logic [NUM_REQ-1:0]      drop_err,
    output logic [31:0]             s2_dataa,
    output logic [31:0]             s2_datab,
    output logic [2:0]              s2_n,
    output logic                    s2_start,
    input  logic [31:0]             s2_result,
    input  logic                    s2_done
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [IDXW-1:0]   gnt_reg, gnt_next;
    logic [IDXW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNTW-1:0]   cnt_reg, cnt_next;
    logic [31:0]       result_reg, result_next;
    logic              timeout_reg, timeout_next;
    logic [31:0]       s2_dataa_reg, s2_dataa_next;
    logic [31:0]       s2_datab_reg, s2_datab_next;
    logic [2:0]        s2_n_reg, s2_n_next;

    // Slot storage, gathered from the per-slot generate blocks
    logic [2:0]        slot_n [NUM_REQ];
    logic [31:0]       slot_a [NUM_REQ];
    logic [31:0]       slot_b [NUM_REQ];
    logic [NUM_REQ-1:0] pending_vec;
    logic [NUM_REQ-1:0] drop_vec;
    logic [NUM_REQ-1:0] answering;

    // ------------------------------------------------------------------
    // Per-slot capture. Runs every cycle regardless of the FSM so a
    // requester can always post, even while the unit is busy.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gen_slot
            logic [2:0]  n_reg;
            logic [31:0] a_reg;
            logic [31:0] b_reg;
            logic        pending_reg;
            logic        drop_reg;

            // Slot is in its response cycle: pending would normally clear
            assign answering[gi] = (state_reg == RESP) && (gnt_reg == IDXW'(gi));

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    n_reg       <= '0;
                    a_reg       <= '0;
                    b_reg       <= '0;
                    pending_reg <= 1'b0;
                    drop_reg    <= 1'b0;
                end else if (req_start[gi] && (!pending_reg || answering[gi])) begin
                    // Free slot, or a re-request landing in the slot's own
                    // response cycle: the new request replaces the answered
                    // one and the slot stays pending.
                    n_reg       <= req_n[3*gi +: 3];
                    a_reg       <= req_dataa[32*gi +: 32];
                    b_reg       <= req_datab[32*gi +: 32];
                    pending_reg <= 1'b1;
                end else if (req_start[gi]) begin
                    // Slot busy: keep the first operands, flag the loss
                    drop_reg    <= 1'b1;
                end else if (answering[gi]) begin
                    pending_reg <= 1'b0;
                end
            end

            assign slot_n[gi]      = n_reg;
            assign slot_a[gi]      = a_reg;
            assign slot_b[gi]      = b_reg;
            assign pending_vec[gi] = pending_reg;
            assign drop_vec[gi]    = drop_reg;
            assign req_done[gi]    = answering[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin search: first pending slot at or above rr_ptr, wrapping
    // ------------------------------------------------------------------
    logic            found;
    logic [IDXW-1:0] pick;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && pending_vec[(int'(rr_ptr_reg) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = IDXW'((int'(rr_ptr_reg) + k) % NUM_REQ);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            rr_ptr_reg   <= '0;
            cnt_reg      <= '0;
            result_reg   <= '0;
            timeout_reg  <= 1'b0;
            s2_dataa_reg <= '0;
            s2_datab_reg <= '0;
            s2_n_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            rr_ptr_reg   <= rr_ptr_next;
            cnt_reg      <= cnt_next;
            result_reg   <= result_next;
            timeout_reg  <= timeout_next;
            s2_dataa_reg <= s2_dataa_next;
            s2_datab_reg <= s2_datab_next;
            s2_n_reg     <= s2_n_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        rr_ptr_next   = rr_ptr_reg;
        cnt_next      = cnt_reg;
        result_next   = result_reg;
        timeout_next  = timeout_reg;
        s2_dataa_next = s2_dataa_reg;
        s2_datab_next = s2_datab_reg;
        s2_n_next     = s2_n_reg;

        case (state_reg)
            IDLE: begin
                // s2_done is deliberately ignored here (late done after reset)
                if (found) begin
                    gnt_next      = pick;
                    // Operands are loaded at grant time so they are already
                    // on the bus during the ISSUE cycle. The slot cannot
                    // change in between: it is pending, so new starts drop.
                    s2_n_next     = slot_n[pick];
                    s2_dataa_next = slot_a[pick];
                    s2_datab_next = slot_b[pick];
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                if (s2_done) begin
                    result_next  = s2_result;
                    timeout_next = 1'b0;
                    state_next   = RESP;
                end else begin
                    cnt_next   = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (s2_done) begin
                    result_next  = s2_result;
                    timeout_next = 1'b0;
                    state_next   = RESP;
                end else if (cnt_reg == CNTW'(TIMEOUT_CYCLES - 1)) begin
                    result_next  = '0;
                    timeout_next = 1'b1;
                    state_next   = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP: begin
                rr_ptr_next = (gnt_reg == IDXW'(NUM_REQ - 1)) ? '0 : gnt_reg + 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s2_start    = (state_reg == ISSUE);
    assign s2_dataa    = s2_dataa_reg;
    assign s2_datab    = s2_datab_reg;
    assign s2_n        = s2_n_reg;
    assign req_result  = result_reg;
    assign req_timeout = (state_reg == RESP) && timeout_reg;
    assign req_pending = pending_vec;
    assign drop_err    = drop_vec;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Testbench for fpu_share_arbiter: directed vectors, scoreboard queues for
// FPU issues and requester responses, a behavioural FPU with programmable
// latency, and a negedge monitor that checks every s2_start and req_done.

module tb_fpu_share_arbiter;

    localparam int NR = 4;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [NR-1:0]     req_start;
    logic [3*NR-1:0]   req_n;
    logic [32*NR-1:0]  req_dataa;
    logic [32*NR-1:0]  req_datab;
    logic [NR-1:0]     req_done;
    logic [31:0]       req_result;
    logic              req_timeout;
    logic [NR-1:0]     req_pending;
    logic [NR-1:0]     drop_err;
    logic [31:0]       s2_dataa;
    logic [31:0]       s2_datab;
    logic [2:0]        s2_n;
    logic              s2_start;
    logic [31:0]       s2_result;
    logic              s2_done;

    fpu_share_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(64)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .req_start   (req_start),
        .req_n       (req_n),
        .req_dataa   (req_dataa),
        .req_datab   (req_datab),
        .req_done    (req_done),
        .req_result  (req_result),
        .req_timeout (req_timeout),
        .req_pending (req_pending),
        .drop_err    (drop_err),
        .s2_dataa    (s2_dataa),
        .s2_datab    (s2_datab),
        .s2_n        (s2_n),
        .s2_start    (s2_start),
        .s2_result   (s2_result),
        .s2_done     (s2_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  n;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        int          slot;
        logic [31:0] result;
        logic        tmo;
        int          gap;     // cycles from ISSUE to RESP
    } resp_t;

    op_t   iq[$];
    resp_t sb[$];
    op_t   mon_op;
    resp_t mon_resp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cyc = 0;

    // FPU model controls
    int          fpu_lat = 2;
    bit          drop_next = 1'b0;
    int          cd = 0;
    logic [31:0] pend_res;

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural FPU: only the vectors used below are known
    function automatic logic [31:0] fpu_model(logic [2:0] n, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        case (n)
            3'b010: case (a)
                32'd1: r = 32'h3F80_0000;
                32'd2: r = 32'h4000_0000;
                32'd3: r = 32'h4040_0000;
                32'd4: r = 32'h4080_0000;
                32'd5: r = 32'h40A0_0000;
                32'd6: r = 32'h40C0_0000;
                32'd7: r = 32'h40E0_0000;
                32'd8: r = 32'h4100_0000;
                default: r = 32'hFFFF_FFFF;
            endcase
            3'b100: if (a == 32'h4000_0000 && b == 32'h4040_0000) r = 32'h40C0_0000;
            3'b001: if (a == 32'h4120_0000) r = 32'd10;
            default: r = 32'hFFFF_FFFF;
        endcase
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expect_op(logic [2:0] n, logic [31:0] a, logic [31:0] b);
        op_t o;
        o.n = n; o.a = a; o.b = b;
        iq.push_back(o);
    endtask

    task automatic expect_resp(int slot, logic [31:0] res, logic tmo, int gap);
        resp_t r;
        r.slot = slot; r.result = res; r.tmo = tmo; r.gap = gap;
        sb.push_back(r);
    endtask

    task automatic set_slot(int s, logic [2:0] n, logic [31:0] a, logic [31:0] b);
        req_start[s]         = 1'b1;
        req_n[3*s +: 3]      = n;
        req_dataa[32*s +: 32] = a;
        req_datab[32*s +: 32] = b;
    endtask

    task automatic drain(string name, int max);
        int c;
        for (c = 0; c < max; c++) begin
            @(negedge CLK);
            if (sb.size() == 0 && iq.size() == 0 && req_pending == '0) break;
        end
        checks++;
        if (c >= max) begin
            errors++;
            $display("FAIL %s_drain actual=busy_after_%0d_cycles required=idle", name, max);
        end
        @(negedge CLK);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_req_done"},    32'(req_done),    32'h0);
        check({tag, "_req_result"},  req_result,       32'h0);
        check({tag, "_req_timeout"}, 32'(req_timeout), 32'h0);
        check({tag, "_req_pending"}, 32'(req_pending), 32'h0);
        check({tag, "_drop_err"},    32'(drop_err),    32'h0);
        check({tag, "_s2_start"},    32'(s2_start),    32'h0);
        check({tag, "_s2_dataa"},    s2_dataa,         32'h0);
        check({tag, "_s2_datab"},    s2_datab,         32'h0);
        check({tag, "_s2_n"},        32'(s2_n),        32'h0);
    endtask

    // FPU model: done after fpu_lat cycles of WAIT, or in the ISSUE cycle
    // itself when fpu_lat is 0; drop_next swallows one op entirely.
    initial begin
        s2_done   = 1'b0;
        s2_result = '0;
        forever begin
            @(negedge CLK);
            if (s2_done) s2_done = 1'b0;
            if (s2_start === 1'b1) begin
                if (drop_next) begin
                    drop_next = 1'b0;
                end else if (fpu_lat == 0) begin
                    s2_done   = 1'b1;
                    s2_result = fpu_model(s2_n, s2_dataa, s2_datab);
                end else begin
                    cd       = fpu_lat;
                    pend_res = fpu_model(s2_n, s2_dataa, s2_datab);
                end
            end else if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    s2_done   = 1'b1;
                    s2_result = pend_res;
                end
            end
        end
    end

    // Monitor: one line per transaction
    always @(negedge CLK) begin
        if (s2_start === 1'b1) begin
            issue_cyc = cyc;
            $display("issue  cyc=%0d n=%b a=%h b=%h", cyc, s2_n, s2_dataa, s2_datab);
            if (iq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual=n%b_a%h required=no_issue", s2_n, s2_dataa);
            end else begin
                mon_op = iq.pop_front();
                check("issue_n", 32'(s2_n), 32'(mon_op.n));
                check("issue_a", s2_dataa, mon_op.a);
                check("issue_b", s2_datab, mon_op.b);
            end
        end
        if (req_done !== '0) begin
            $display("done   cyc=%0d vec=%b result=%h timeout=%b", cyc, req_done, req_result, req_timeout);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%b required=none", req_done);
            end else begin
                mon_resp = sb.pop_front();
                check("done_vec",     32'(req_done),    32'(1) << mon_resp.slot);
                check("done_result",  req_result,       mon_resp.result);
                check("done_timeout", 32'(req_timeout), 32'(mon_resp.tmo));
                check("done_gap",     32'(cyc - issue_cyc), 32'(mon_resp.gap));
            end
        end
    end

    initial begin
        int re0;
        int re1;
        int c;

        RESET     = 1'b1;
        req_start = '0;
        req_n     = '0;
        req_dataa = '0;
        req_datab = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        // Simultaneous starts on 0, 2, 3 from rr_ptr 0
        fpu_lat = 2;
        set_slot(0, 3'b010, 32'd4, 32'd0);
        set_slot(2, 3'b100, 32'h4000_0000, 32'h4040_0000);
        set_slot(3, 3'b001, 32'h4120_0000, 32'd0);
        expect_op(3'b010, 32'd4, 32'd0);
        expect_op(3'b100, 32'h4000_0000, 32'h4040_0000);
        expect_op(3'b001, 32'h4120_0000, 32'd0);
        expect_resp(0, 32'h4080_0000, 1'b0, 3);
        expect_resp(2, 32'h40C0_0000, 1'b0, 3);
        expect_resp(3, 32'd10,        1'b0, 3);
        @(negedge CLK);
        req_start = '0;
        drain("simul", 100);

        // Fairness: 0 and 1 re-request in their own RESP cycle
        set_slot(0, 3'b010, 32'd1, 32'd0);
        set_slot(1, 3'b010, 32'd2, 32'd0);
        expect_op(3'b010, 32'd1, 32'd0);
        expect_op(3'b010, 32'd2, 32'd0);
        expect_op(3'b010, 32'd3, 32'd0);
        expect_op(3'b010, 32'd4, 32'd0);
        expect_op(3'b010, 32'd5, 32'd0);
        expect_op(3'b010, 32'd6, 32'd0);
        expect_resp(0, 32'h3F80_0000, 1'b0, 3);
        expect_resp(1, 32'h4000_0000, 1'b0, 3);
        expect_resp(0, 32'h4040_0000, 1'b0, 3);
        expect_resp(1, 32'h4080_0000, 1'b0, 3);
        expect_resp(0, 32'h40A0_0000, 1'b0, 3);
        expect_resp(1, 32'h40C0_0000, 1'b0, 3);
        re0 = 0;
        re1 = 0;
        for (c = 0; c < 300; c++) begin
            @(negedge CLK);
            req_start = '0;
            if (req_done[0] && re0 < 2) begin
                re0++;
                set_slot(0, 3'b010, (re0 == 1) ? 32'd3 : 32'd5, 32'd0);
            end
            if (req_done[1] && re1 < 2) begin
                re1++;
                set_slot(1, 3'b010, (re1 == 1) ? 32'd4 : 32'd6, 32'd0);
            end
            if (re0 == 2 && re1 == 2 && sb.size() == 0) break;
        end
        req_start = '0;
        drain("fair", 100);
        check("fair_drop_err", 32'(drop_err), 32'h0);

        // Single int->float, FPU latency 4
        fpu_lat = 4;
        set_slot(0, 3'b010, 32'd5, 32'd0);
        expect_op(3'b010, 32'd5, 32'd0);
        expect_resp(0, 32'h40A0_0000, 1'b0, 5);
        @(negedge CLK);
        req_start = '0;
        check("single_pending", 32'(req_pending), 32'h1);
        drain("single", 100);
        check("single_pending_clear", 32'(req_pending), 32'h0);

        // Timeout on slot 2, then slot 3 served normally
        fpu_lat   = 2;
        drop_next = 1'b1;
        set_slot(2, 3'b010, 32'd3, 32'd0);
        set_slot(3, 3'b010, 32'd7, 32'd0);
        expect_op(3'b010, 32'd3, 32'd0);
        expect_op(3'b010, 32'd7, 32'd0);
        expect_resp(2, 32'h0,         1'b1, 65);
        expect_resp(3, 32'h40E0_0000, 1'b0, 3);
        @(negedge CLK);
        req_start = '0;
        drain("timeout", 300);

        // Drop: second start on pending slot 2 with different operands
        set_slot(2, 3'b010, 32'd3, 32'd0);
        expect_op(3'b010, 32'd3, 32'd0);
        expect_resp(2, 32'h4040_0000, 1'b0, 3);
        @(negedge CLK);
        req_start = '0;
        set_slot(2, 3'b010, 32'd9, 32'd0);
        @(negedge CLK);
        req_start = '0;
        check("drop_err_set", 32'(drop_err), 32'h4);
        drain("drop", 100);
        check("drop_err_sticky", 32'(drop_err), 32'h4);

        // Zero-latency op: done during ISSUE
        fpu_lat = 0;
        set_slot(1, 3'b010, 32'd8, 32'd0);
        expect_op(3'b010, 32'd8, 32'd0);
        expect_resp(1, 32'h4100_0000, 1'b0, 1);
        @(negedge CLK);
        req_start = '0;
        drain("zerolat", 100);

        // Reset mid-WAIT; late s2_done must be ignored, no req_done
        fpu_lat = 10;
        set_slot(1, 3'b010, 32'd1, 32'd0);
        expect_op(3'b010, 32'd1, 32'd0);
        @(negedge CLK);
        req_start = '0;
        for (c = 0; c < 50; c++) begin
            if (iq.size() == 0) break;
            @(negedge CLK);
        end
        checks++;
        if (c >= 50) begin
            errors++;
            $display("FAIL rstwait_issue actual=not_issued required=issued");
        end
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (20) @(negedge CLK);
        check("post_reset_pending", 32'(req_pending), 32'h0);
        check("post_reset_done", 32'(req_done), 32'h0);
        check("final_sb_empty", 32'(sb.size()), 32'h0);
        check("final_iq_empty", 32'(iq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
